// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard / forwarding controller.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, hold at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, stall and forwarding controller for the 5-stage pipeline, with a
// busy scoreboard for the multi-cycle multiply/divide unit.
// Optional stall performance counters are built when HAZARD_PERF_EN is defined;
// otherwise the counter ports read 0 and perf_clr is ignored.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  input  logic              md_start_d,
  input  logic              md_read_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] regaddr_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] regaddr_m,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] regaddr_w,
  input  logic              regwrite_w,
  input  logic              perf_clr,
  output logic              stall_pc,
  output logic              stall_decode,
  output logic              flush_exe,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output fwd_sel_t          fwd_a_e,
  output fwd_sel_t          fwd_b_e,
  output logic              md_busy,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_lw,
  output logic [CNT_W-1:0]  cnt_br,
  output logic [CNT_W-1:0]  cnt_md
);

  localparam int MD_W = 4;

  logic            src_e_hit;
  logic            src_m_hit;
  logic            lwstall;
  logic            brstall;
  logic            mdstall;
  logic            stall;
  logic [MD_W-1:0] md_cnt;

  // Register 0 is hardwired to zero, so it never carries a dependency.
  function automatic logic addr_hit(input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  // EXE operand selects: the younger MEM result wins over WB.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (regwrite_m && addr_hit(rs_e, regaddr_m)) begin
      fwd_a_e = FWD_MEM;
    end else if (regwrite_w && addr_hit(rs_e, regaddr_w)) begin
      fwd_a_e = FWD_WB;
    end
    if (regwrite_m && addr_hit(rt_e, regaddr_m)) begin
      fwd_b_e = FWD_MEM;
    end else if (regwrite_w && addr_hit(rt_e, regaddr_w)) begin
      fwd_b_e = FWD_WB;
    end
  end

  // DECODE dependency detection, branch forwarding and stall causes.
  always_comb begin
    src_e_hit = (use_rs_d && addr_hit(rs_d, regaddr_e)) ||
                (use_rt_d && addr_hit(rt_d, regaddr_e));
    src_m_hit = (use_rs_d && addr_hit(rs_d, regaddr_m)) ||
                (use_rt_d && addr_hit(rt_d, regaddr_m));
    // A load in MEM has no data yet, so it cannot feed the branch comparator.
    fwd_a_d   = use_rs_d && addr_hit(rs_d, regaddr_m) && regwrite_m && !memtoreg_m;
    fwd_b_d   = use_rt_d && addr_hit(rt_d, regaddr_m) && regwrite_m && !memtoreg_m;
    lwstall   = memtoreg_e && regwrite_e && src_e_hit;
    brstall   = branch_d && ((regwrite_e && src_e_hit) || (memtoreg_m && src_m_hit));
    mdstall   = (md_start_d || md_read_d) && (md_cnt != '0);
    stall     = lwstall || brstall || mdstall;
  end

  assign stall_pc     = stall;
  assign stall_decode = stall;
  assign flush_exe    = stall;
  assign md_busy      = (md_cnt != '0);

  generate
    if (MD_LAT == 0) begin : g_md_off
      assign md_cnt = '0;
    end else begin : g_md_on
      localparam logic [MD_W-1:0] LAT = MD_W'(MD_LAT);

      // Busy down-counter: loads on an accepted mult/div, then runs to zero.
      // A start while busy is itself stalled, so operations never overlap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          md_cnt <= '0;
        end else if (md_start_d && !stall) begin
          md_cnt <= LAT;
        end else if (md_cnt != '0) begin
          md_cnt <= md_cnt - MD_W'(1);
        end
      end
    end
  endgenerate

`ifdef HAZARD_PERF_EN
  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (stall),
    .q     (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_lw (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (lwstall),
    .q     (cnt_lw)
  );

  sat_counter #(.W(CNT_W)) u_cnt_br (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (brstall),
    .q     (cnt_br)
  );

  sat_counter #(.W(CNT_W)) u_cnt_md (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (mdstall),
    .q     (cnt_md)
  );
`else
  logic perf_clr_unused;

  assign perf_clr_unused = perf_clr;
  assign cnt_stall       = '0;
  assign cnt_lw          = '0;
  assign cnt_br          = '0;
  assign cnt_md          = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int LAT  = 4;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, regaddr_e, regaddr_m, regaddr_w;
  logic       use_rs_d, use_rt_d, branch_d, md_start_d, md_read_d;
  logic       regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w, perf_clr;
  logic       stall_pc, stall_decode, flush_exe, fwd_a_d, fwd_b_d, md_busy;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [3:0] cnt_stall, cnt_lw, cnt_br, cnt_md;
  logic       stall_pc0, stall_decode0, flush_exe0, fwd_a_d0, fwd_b_d0, md_busy0;
  logic [1:0] fwd_a_e0, fwd_b_e0;
  logic [3:0] cnt_stall0, cnt_lw0, cnt_br0, cnt_md0;

  int checks = 0;
  int errors = 0;

  // model state: a mult/div is in flight while cyc <= busy_until
  int cyc = 0;
  int busy_until = -100;
  int busy0_until = -100;
  int c_stall = 0, c_lw = 0, c_br = 0, c_md = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .MD_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d),
    .use_rt_d(use_rt_d), .branch_d(branch_d), .md_start_d(md_start_d),
    .md_read_d(md_read_d), .rs_e(rs_e), .rt_e(rt_e), .regaddr_e(regaddr_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .regaddr_m(regaddr_m),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .regaddr_w(regaddr_w),
    .regwrite_w(regwrite_w), .perf_clr(perf_clr), .stall_pc(stall_pc),
    .stall_decode(stall_decode), .flush_exe(flush_exe), .fwd_a_d(fwd_a_d),
    .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .md_busy(md_busy),
    .cnt_stall(cnt_stall), .cnt_lw(cnt_lw), .cnt_br(cnt_br), .cnt_md(cnt_md)
  );

  hazard_scoreboard #(.REG_AW(5), .MD_LAT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d),
    .use_rt_d(use_rt_d), .branch_d(branch_d), .md_start_d(md_start_d),
    .md_read_d(md_read_d), .rs_e(rs_e), .rt_e(rt_e), .regaddr_e(regaddr_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .regaddr_m(regaddr_m),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .regaddr_w(regaddr_w),
    .regwrite_w(regwrite_w), .perf_clr(perf_clr), .stall_pc(stall_pc0),
    .stall_decode(stall_decode0), .flush_exe(flush_exe0), .fwd_a_d(fwd_a_d0),
    .fwd_b_d(fwd_b_d0), .fwd_a_e(fwd_a_e0), .fwd_b_e(fwd_b_e0), .md_busy(md_busy0),
    .cnt_stall(cnt_stall0), .cnt_lw(cnt_lw0), .cnt_br(cnt_br0), .cnt_md(cnt_md0)
  );

  // ---------------- behavioural reference model ----------------
  function automatic bit hit(input logic [4:0] src, input bit used, input logic [4:0] dst);
    return used && (src != 0) && (src == dst);
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_until;
  endfunction

  function automatic bit m_busy0();
    return cyc <= busy0_until;
  endfunction

  function automatic bit exp_lw();
    return memtoreg_e && regwrite_e &&
           (hit(rs_d, use_rs_d, regaddr_e) || hit(rt_d, use_rt_d, regaddr_e));
  endfunction

  function automatic bit exp_br();
    bit dep_e = hit(rs_d, use_rs_d, regaddr_e) || hit(rt_d, use_rt_d, regaddr_e);
    bit dep_m = hit(rs_d, use_rs_d, regaddr_m) || hit(rt_d, use_rt_d, regaddr_m);
    return branch_d && ((regwrite_e && dep_e) || (memtoreg_m && dep_m));
  endfunction

  function automatic bit exp_md(input bit busy);
    return (md_start_d || md_read_d) && busy;
  endfunction

  function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
    if (src != 0 && src == regaddr_m && regwrite_m) return 2'b10;
    if (src != 0 && src == regaddr_w && regwrite_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_fwd_d(input logic [4:0] src, input bit used);
    return hit(src, used, regaddr_m) && regwrite_m && !memtoreg_m;
  endfunction

  function automatic logic [3:0] cexp(input int c);
    if (!PERF) return 4'd0;
    return (c > CMAX) ? 4'(CMAX) : 4'(c);
  endfunction

  // advance one clock, updating the model with what happens at that edge
  task automatic tick();
    bit lw, br, md, md0;
    if (rst_n) begin
      lw  = exp_lw();
      br  = exp_br();
      md  = exp_md(m_busy());
      md0 = exp_md(m_busy0());
      if (md_start_d && !(lw || br || md)) busy_until = cyc + LAT;
      if (md_start_d && !(lw || br || md0)) busy0_until = cyc;
      if (perf_clr) begin
        c_stall = 0; c_lw = 0; c_br = 0; c_md = 0;
      end else begin
        c_stall += int'(lw || br || md);
        c_lw    += int'(lw);
        c_br    += int'(br);
        c_md    += int'(md);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, regaddr_e, regaddr_m, regaddr_w} = '0;
    {use_rs_d, use_rt_d, branch_d, md_start_d, md_read_d} = '0;
    {regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w, perf_clr} = '0;
  endtask

  task automatic model_reset();
    busy_until = -100; busy0_until = -100;
    c_stall = 0; c_lw = 0; c_br = 0; c_md = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({stall_pc, stall_decode, flush_exe, fwd_a_d, fwd_b_d, md_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {stall_pc, stall_decode, flush_exe, fwd_a_d, fwd_b_d, md_busy});
    end
    checks++;
    if ({fwd_a_e, fwd_b_e} !== 4'b0) begin
      errors++; $display("FAIL reset_fwd_e: got %b required 0000", {fwd_a_e, fwd_b_e});
    end
    checks++;
    if ({cnt_stall, cnt_lw, cnt_br, cnt_md} !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %h required 0000", {cnt_stall, cnt_lw, cnt_br, cnt_md});
    end
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic test_exe_fwd();
    clear_inputs();
    rs_e = 5; rt_e = 5; regaddr_m = 5; regwrite_m = 1; regaddr_w = 5; regwrite_w = 1;
    #2;
    checks++;
    if (fwd_a_e !== 2'b10) begin errors++; $display("FAIL fwd_e_mem: got %b required 10", fwd_a_e); end
    checks++;
    if (fwd_b_e !== 2'b10) begin errors++; $display("FAIL fwd_e_mem_b: got %b required 10", fwd_b_e); end
    regwrite_m = 0;
    #2;
    checks++;
    if (fwd_a_e !== 2'b01) begin errors++; $display("FAIL fwd_e_wb: got %b required 01", fwd_a_e); end
    rs_e = 0; regaddr_m = 0; regaddr_w = 0; regwrite_m = 1;
    #2;
    checks++;
    if (fwd_a_e !== 2'b00) begin errors++; $display("FAIL fwd_e_r0: got %b required 00", fwd_a_e); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    memtoreg_e = 1; regwrite_e = 1; regaddr_e = 8; rt_d = 8; use_rt_d = 1;
    #2;
    checks++;
    if ({stall_pc, stall_decode, flush_exe} !== 3'b111) begin
      errors++; $display("FAIL lw_stall: got %b required 111", {stall_pc, stall_decode, flush_exe});
    end
    tick();
    memtoreg_e = 0; regwrite_e = 0; regaddr_e = 0;
    regaddr_m = 8; regwrite_m = 1; memtoreg_m = 1;
    #2;
    checks++;
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL lw_one_cycle: got %b required 0", stall_pc); end
    tick();
    clear_inputs();
    memtoreg_e = 1; regwrite_e = 1; regaddr_e = 8; rt_d = 8; use_rt_d = 0;
    #2;
    checks++;
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL lw_unused_rt: got %b required 0", stall_pc); end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_d = 1; rs_d = 3; use_rs_d = 1; regwrite_e = 1; regaddr_e = 3;
    #2;
    checks++;
    if (stall_pc !== 1'b1) begin errors++; $display("FAIL br_exe: got %b required 1", stall_pc); end
    tick();
    regwrite_e = 0; regaddr_e = 0; regaddr_m = 3; regwrite_m = 1;
    #2;
    checks++;
    if ({stall_pc, fwd_a_d} !== 2'b01) begin
      errors++; $display("FAIL br_fwd_mem: got stall,fwd=%b required 01", {stall_pc, fwd_a_d});
    end
    memtoreg_m = 1;
    #2;
    checks++;
    if ({stall_pc, fwd_a_d} !== 2'b10) begin
      errors++; $display("FAIL br_lw_mem: got stall,fwd=%b required 10", {stall_pc, fwd_a_d});
    end
    tick();
  endtask

  task automatic test_md();
    int stalls = 0;
    int busy_cycles = 0;
    bit issued = 0;
    clear_inputs();
    md_start_d = 1;
    #2;
    checks++;
    if ({stall_pc, md_busy} !== 2'b00) begin
      errors++; $display("FAIL md_accept: got stall,busy=%b required 00", {stall_pc, md_busy});
    end
    tick();
    md_start_d = 0; md_read_d = 1;
    for (int i = 0; i < 12 && !issued; i++) begin
      #2;
      busy_cycles += int'(md_busy);
      checks++;
      if (stall_pc0 !== 1'b0 || md_busy0 !== 1'b0) begin
        errors++; $display("FAIL md_lat0: got stall,busy=%b%b required 00", stall_pc0, md_busy0);
      end
      if (stall_pc) stalls++;
      else issued = 1;
      tick();
    end
    checks++;
    if (!issued || stalls != LAT) begin
      errors++; $display("FAIL md_stall_len: got %0d stall cycles required %0d", stalls, LAT);
    end
    checks++;
    if (busy_cycles != LAT) begin
      errors++; $display("FAIL md_busy_len: got %0d busy cycles required %0d", busy_cycles, LAT);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    bit accepted = 0;
    clear_inputs();
    md_start_d = 1;
    tick();
    for (int i = 0; i < 12 && !accepted; i++) begin
      #2;
      if (stall_pc) stalls++;
      else accepted = 1;
      tick();
    end
    checks++;
    if (!accepted || stalls != LAT) begin
      errors++; $display("FAIL md_b2b: got %0d stall cycles required %0d", stalls, LAT);
    end
    clear_inputs();
    #2;
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL md_b2b_busy: got %b required 1", md_busy); end
    repeat (LAT + 1) tick();
  endtask

  task automatic test_reset_mid_md();
    clear_inputs();
    md_start_d = 1;
    tick();
    md_start_d = 0;
    repeat (2) tick();
    #2;
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_pre_rst: got %b required 1", md_busy); end
    rst_n = 1'b0;
    model_reset();
    md_read_d = 1;
    #1;
    checks++;
    if ({md_busy, stall_pc} !== 2'b00) begin
      errors++; $display("FAIL md_rst_async: got busy,stall=%b required 00", {md_busy, stall_pc});
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (stall_pc !== 1'b0) begin errors++; $display("FAIL md_rst_residual: got %b required 0", stall_pc); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_counters();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    memtoreg_e = 1; regwrite_e = 1; regaddr_e = 8; rt_d = 8; use_rt_d = 1;
    repeat (20) tick();
    #2;
    checks++;
    if (cnt_lw !== cexp(c_lw) || cnt_stall !== cexp(c_stall)) begin
      errors++; $display("FAIL cnt_sat: got lw=%0d stall=%0d required %0d", cnt_lw, cnt_stall, cexp(c_lw));
    end
    checks++;
    if (cnt_br !== cexp(c_br) || cnt_md !== cexp(c_md)) begin
      errors++; $display("FAIL cnt_other: got br=%0d md=%0d required %0d", cnt_br, cnt_md, cexp(c_br));
    end
    perf_clr = 1;
    tick();
    perf_clr = 0;
    clear_inputs();
    #2;
    checks++;
    if ({cnt_stall, cnt_lw} !== {cexp(c_stall), cexp(c_lw)}) begin
      errors++; $display("FAIL cnt_clr: got stall=%0d lw=%0d required 0", cnt_stall, cnt_lw);
    end
    branch_d = 1; rs_d = 8; use_rs_d = 1; regaddr_e = 8; regwrite_e = 1; memtoreg_e = 1;
    tick();
    clear_inputs();
    #2;
    checks++;
    if ({cnt_stall, cnt_lw, cnt_br} !== {cexp(c_stall), cexp(c_lw), cexp(c_br)}) begin
      errors++; $display("FAIL cnt_multi: got stall=%0d lw=%0d br=%0d required %0d each",
                         cnt_stall, cnt_lw, cnt_br, cexp(1));
    end
    tick();
  endtask

  task automatic test_random();
    bit lw, br, md, st;
    for (int i = 0; i < 400; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      regaddr_e = 5'($urandom_range(0, 3)); regaddr_m = 5'($urandom_range(0, 3));
      regaddr_w = 5'($urandom_range(0, 3));
      {use_rs_d, use_rt_d, branch_d} = 3'($urandom);
      {regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w} = 5'($urandom);
      md_start_d = ($urandom_range(0, 7) == 0);
      md_read_d  = ($urandom_range(0, 3) == 0);
      perf_clr   = ($urandom_range(0, 31) == 0);
      #2;
      lw = exp_lw(); br = exp_br(); md = exp_md(m_busy()); st = lw || br || md;
      checks++;
      if ({stall_pc, stall_decode, flush_exe} !== {3{st}}) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b required %b", i,
                           {stall_pc, stall_decode, flush_exe}, {3{st}});
      end
      checks++;
      if ({fwd_a_e, fwd_b_e} !== {exp_fwd_e(rs_e), exp_fwd_e(rt_e)}) begin
        errors++; $display("FAIL rnd_fwd_e[%0d]: got %b required %b", i,
                           {fwd_a_e, fwd_b_e}, {exp_fwd_e(rs_e), exp_fwd_e(rt_e)});
      end
      checks++;
      if ({fwd_a_d, fwd_b_d} !== {exp_fwd_d(rs_d, use_rs_d), exp_fwd_d(rt_d, use_rt_d)}) begin
        errors++; $display("FAIL rnd_fwd_d[%0d]: got %b required %b", i, {fwd_a_d, fwd_b_d},
                           {exp_fwd_d(rs_d, use_rs_d), exp_fwd_d(rt_d, use_rt_d)});
      end
      checks++;
      if (md_busy !== m_busy()) begin
        errors++; $display("FAIL rnd_busy[%0d]: got %b required %b", i, md_busy, m_busy());
      end
      checks++;
      if ({cnt_stall, cnt_lw, cnt_br, cnt_md} !== {cexp(c_stall), cexp(c_lw), cexp(c_br), cexp(c_md)}) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %h required %h", i, {cnt_stall, cnt_lw, cnt_br, cnt_md},
                           {cexp(c_stall), cexp(c_lw), cexp(c_br), cexp(c_md)});
      end
      checks++;
      if ({stall_pc0, md_busy0, cnt_md0} !== {(lw || br), 1'b0, 4'd0}) begin
        errors++; $display("FAIL rnd_lat0[%0d]: got stall=%b busy=%b cnt_md=%0d required %b 0 0",
                           i, stall_pc0, md_busy0, cnt_md0, (lw || br));
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    test_reset();
    test_exe_fwd();
    test_load_use();
    test_branch();
    test_md();
    test_back_to_back();
    test_reset_mid_md();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
